// File: rtl/pdp1_tty_pkg.sv
// Shared state type, FIO-DEC case codes and defaults for the PDP-1 typewriter input path.
package pdp1_tty_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHAR,
    DONE
  } tty_state_e;

  localparam logic [5:0]  FIODEC_LOWER           = 6'o72;
  localparam logic [5:0]  FIODEC_UPPER           = 6'o74;
  localparam logic [23:0] DEFAULT_TIMEOUT_CYCLES = 24'd1_000_000;

  function automatic logic is_case_code(input logic [5:0] code);
    return (code == FIODEC_LOWER) || (code == FIODEC_UPPER);
  endfunction

  // Case-change code carries the target case in bit 6, like any other character.
  function automatic logic [6:0] shift_code(input logic upper);
    return {upper, (upper ? FIODEC_UPPER : FIODEC_LOWER)};
  endfunction

endpackage

// File: rtl/tty_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module tty_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  logic last_b_q;
  logic last_b_d;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_b_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    last_b_d = last_b_q;
    if (update_i && (grant_o != 2'b00)) begin
      last_b_d = grant_o[1];
    end
  end

  // Reset to "B granted last" so requester A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/tty_input_arbiter.sv
// Merges two character sources into the CPU typewriter read port, tracking case.
// Define TTY_AUTO_CASE_EN to insert case-shift codes automatically before characters.
module tty_input_arbiter
  import pdp1_tty_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       a_req,
  input  logic [6:0] a_char,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [6:0] b_char,
  output logic       b_ack,
  output logic       kbd_read_strobe,
  output logic [6:0] kbd_char_out,
  input  logic       key_was_processed,
  output logic       current_case,
  output logic       timeout_err
);

  tty_state_e  state_q,  state_d;
  logic [6:0]  char_q,   char_d;
  logic        gnt_b_q,  gnt_b_d;
  logic        strobe_q, strobe_d;
  logic [6:0]  out_q,    out_d;
  logic        case_q,   case_d;
  logic [23:0] cnt_q,    cnt_d;
  logic        a_ack_q,  a_ack_d;
  logic        b_ack_q,  b_ack_d;
  logic        tout_q,   tout_d;
  logic        kwp_q;

  logic [1:0]  grant;
  logic        arb_update;
  logic [6:0]  sel_char;
  logic        need_shift;
  logic        kwp_rise;
  logic        timeout_hit;

  tty_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (reset_n),
    .req_i    ({b_req, a_req}),
    .update_i (arb_update),
    .grant_o  (grant)
  );

  assign sel_char    = grant[1] ? b_char : a_char;
  assign kwp_rise    = key_was_processed && !kwp_q;
  assign timeout_hit = strobe_q && (cnt_q == (TIMEOUT_CYCLES - 24'd1));

`ifdef TTY_AUTO_CASE_EN
  assign need_shift = !is_case_code(sel_char[5:0]) && (sel_char[6] != case_q);
`else
  assign need_shift = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    char_d     = char_q;
    gnt_b_d    = gnt_b_q;
    strobe_d   = strobe_q;
    out_d      = out_q;
    case_d     = case_q;
    cnt_d      = strobe_q ? (cnt_q + 24'd1) : cnt_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    tout_d     = 1'b0;
    arb_update = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          arb_update = 1'b1;
          gnt_b_d    = grant[1];
          char_d     = sel_char;
          strobe_d   = 1'b1;
          cnt_d      = '0;
          if (need_shift) begin
            state_d = SHIFT;
            out_d   = shift_code(sel_char[6]);
          end else begin
            state_d = CHAR;
            out_d   = sel_char;
          end
        end
      end

      SHIFT: begin
        if (kwp_rise) begin
          strobe_d = 1'b0;
          case_d   = char_q[6];
          state_d  = CHAR;
        end else if (timeout_hit) begin
          strobe_d = 1'b0;
          tout_d   = 1'b1;
          a_ack_d  = !gnt_b_q;
          b_ack_d  = gnt_b_q;
          state_d  = DONE;
        end
      end

      // Strobe is low on entry only after a shift, leaving one dead cycle before the character.
      CHAR: begin
        if (!strobe_q) begin
          strobe_d = 1'b1;
          out_d    = char_q;
          cnt_d    = '0;
        end else if (kwp_rise) begin
          strobe_d = 1'b0;
          a_ack_d  = !gnt_b_q;
          b_ack_d  = gnt_b_q;
          if (is_case_code(char_q[5:0])) begin
            case_d = (char_q[5:0] == FIODEC_UPPER);
          end
          state_d = DONE;
        end else if (timeout_hit) begin
          strobe_d = 1'b0;
          tout_d   = 1'b1;
          a_ack_d  = !gnt_b_q;
          b_ack_d  = gnt_b_q;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      char_q   <= '0;
      gnt_b_q  <= 1'b0;
      strobe_q <= 1'b0;
      out_q    <= '0;
      case_q   <= 1'b0;
      cnt_q    <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      tout_q   <= 1'b0;
      kwp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      char_q   <= char_d;
      gnt_b_q  <= gnt_b_d;
      strobe_q <= strobe_d;
      out_q    <= out_d;
      case_q   <= case_d;
      cnt_q    <= cnt_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      tout_q   <= tout_d;
      kwp_q    <= key_was_processed;
    end
  end

  assign kbd_read_strobe = strobe_q;
  assign kbd_char_out    = out_q;
  assign current_case    = case_q;
  assign a_ack           = a_ack_q;
  assign b_ack           = b_ack_q;
  assign timeout_err     = tout_q;

endmodule

// File: tb/tb_tty_input_arbiter.sv
// Self-checking bench for tty_input_arbiter: directed scenarios plus a randomized transaction-level model.
module tb_tty_input_arbiter;

  localparam int T = 16;
`ifdef TTY_AUTO_CASE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0, key = 1'b0;
  logic [6:0] a_char = '0, b_char = '0;
  logic       a_ack, b_ack, strobe, tout, cur_case;
  logic [6:0] char_out;
  logic [4:0] ctl;

  int compared = 0;
  int mismatched = 0;

  assign ctl = {strobe, a_ack, b_ack, tout, cur_case};

  tty_input_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .a_req             (a_req),
    .a_char            (a_char),
    .a_ack             (a_ack),
    .b_req             (b_req),
    .b_char            (b_char),
    .b_ack             (b_ack),
    .kbd_read_strobe   (strobe),
    .kbd_char_out      (char_out),
    .key_was_processed (key),
    .current_case      (cur_case),
    .timeout_err       (tout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0; key = 1'b0; a_char = '0; b_char = '0;
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  function automatic logic [6:0] rand_char();
    logic [5:0] c;
    case ($urandom_range(0, 5))
      0:       c = 6'o72;
      1:       c = 6'o74;
      default: c = 6'($urandom_range(0, 63));
    endcase
    return {1'($urandom_range(0, 1)), c};
  endfunction

  task automatic test_reset();
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    #2;
    compared++; if ({ctl, char_out} !== 12'b0) begin mismatched++; $display("[TB] FAIL reset_async: got %b want %b", {ctl, char_out}, 12'b0); end
    tick();
    reset_n = 1'b1;
    tick();
    compared++; if ({ctl, char_out} !== 12'b0) begin mismatched++; $display("[TB] FAIL reset_release: got %b want %b", {ctl, char_out}, 12'b0); end
  endtask

  task automatic test_lower_char();
    do_reset();
    a_char = 7'o061; a_req = 1'b1;
    tick();
    compared++; if ({ctl, char_out} !== {5'b10000, 7'o061}) begin mismatched++; $display("[TB] FAIL lower_present: got %b/%o want %b/%o", ctl, char_out, 5'b10000, 7'o061); end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++; if (ctl !== 5'b10000) begin mismatched++; $display("[TB] FAIL lower_hold%0d: got %b want %b", i, ctl, 5'b10000); end
    end
    key = 1'b1;
    tick();
    key = 1'b0; a_req = 1'b0;
    compared++; if (ctl !== 5'b01000) begin mismatched++; $display("[TB] FAIL lower_ack: got %b want %b", ctl, 5'b01000); end
    tick();
    compared++; if (ctl !== 5'b00000) begin mismatched++; $display("[TB] FAIL lower_ack_single: got %b want %b", ctl, 5'b00000); end
    tick();
    compared++; if (ctl !== 5'b00000) begin mismatched++; $display("[TB] FAIL lower_idle: got %b want %b", ctl, 5'b00000); end
  endtask

  task automatic test_upper_char();
    logic [6:0] codes[$];
    do_reset();
    codes.delete();
    if (AUTO) codes.push_back(7'o174);
    codes.push_back(7'o161);
    b_char = 7'o161; b_req = 1'b1;
    tick();
    for (int k = 0; k < codes.size(); k++) begin
      if (k > 0) begin
        compared++; if (ctl !== 5'b00001) begin mismatched++; $display("[TB] FAIL upper_gap_case: got %b want %b", ctl, 5'b00001); end
        tick();
      end
      compared++; if ({strobe, char_out} !== {1'b1, codes[k]}) begin mismatched++; $display("[TB] FAIL upper_code%0d: got %b/%o want 1/%o", k, strobe, char_out, codes[k]); end
      tick();
      key = 1'b1;
      tick();
      key = 1'b0;
    end
    b_req = 1'b0;
    compared++; if (ctl !== {4'b0010, AUTO}) begin mismatched++; $display("[TB] FAIL upper_ack: got %b want %b", ctl, {4'b0010, AUTO}); end
    tick(); tick();
    compared++; if (ctl !== {4'b0000, AUTO}) begin mismatched++; $display("[TB] FAIL upper_after: got %b want %b", ctl, {4'b0000, AUTO}); end
  endtask

  task automatic test_round_robin();
    do_reset();
    a_char = 7'o061; b_char = 7'o062; a_req = 1'b1; b_req = 1'b1;
    tick();
    compared++; if ({strobe, char_out} !== {1'b1, 7'o061}) begin mismatched++; $display("[TB] FAIL rr_first_a: got %b/%o want 1/%o", strobe, char_out, 7'o061); end
    tick(); key = 1'b1; tick(); key = 1'b0;
    compared++; if (ctl !== 5'b01000) begin mismatched++; $display("[TB] FAIL rr_a_ack: got %b want %b", ctl, 5'b01000); end
    a_char = 7'o063;
    tick(); tick();
    compared++; if ({strobe, char_out} !== {1'b1, 7'o062}) begin mismatched++; $display("[TB] FAIL rr_then_b: got %b/%o want 1/%o", strobe, char_out, 7'o062); end
    tick(); key = 1'b1; tick(); key = 1'b0;
    b_req = 1'b0;
    compared++; if (ctl !== 5'b00100) begin mismatched++; $display("[TB] FAIL rr_b_ack: got %b want %b", ctl, 5'b00100); end
    tick(); tick();
    compared++; if ({strobe, char_out} !== {1'b1, 7'o063}) begin mismatched++; $display("[TB] FAIL rr_then_a: got %b/%o want 1/%o", strobe, char_out, 7'o063); end
    tick(); key = 1'b1; tick(); key = 1'b0;
    a_req = 1'b0;
    compared++; if (ctl !== 5'b01000) begin mismatched++; $display("[TB] FAIL rr_a_ack2: got %b want %b", ctl, 5'b01000); end
    tick(); tick();
  endtask

  task automatic test_timeout();
    do_reset();
    a_char = 7'o074; a_req = 1'b1;
    tick(); key = 1'b1; tick(); key = 1'b0; a_req = 1'b0;
    tick();
    compared++; if (cur_case !== 1'b1) begin mismatched++; $display("[TB] FAIL to_case_set: got %b want 1", cur_case); end
    b_char = 7'o161; b_req = 1'b1;
    tick();
    for (int i = 1; i < T; i++) tick();
    compared++; if (ctl !== 5'b10001) begin mismatched++; $display("[TB] FAIL to_still_high: got %b want %b", ctl, 5'b10001); end
    tick();
    b_req = 1'b0;
    compared++; if (ctl !== 5'b00111) begin mismatched++; $display("[TB] FAIL to_drop: got %b want %b", ctl, 5'b00111); end
    tick();
    compared++; if (ctl !== 5'b00001) begin mismatched++; $display("[TB] FAIL to_single: got %b want %b", ctl, 5'b00001); end
    tick();
  endtask

  task automatic test_reset_midtransfer();
    do_reset();
    a_char = 7'o074; a_req = 1'b1;
    tick(); key = 1'b1; tick(); key = 1'b0; a_req = 1'b0;
    tick();
    b_char = 7'o161; b_req = 1'b1;
    tick(); tick();
    compared++; if (ctl !== 5'b10001) begin mismatched++; $display("[TB] FAIL mid_active: got %b want %b", ctl, 5'b10001); end
    #2 reset_n = 1'b0;
    #1;
    compared++; if ({ctl, char_out} !== 12'b0) begin mismatched++; $display("[TB] FAIL mid_async: got %b want %b", {ctl, char_out}, 12'b0); end
    b_req = 1'b0;
    tick();
    compared++; if (ctl !== 5'b00000) begin mismatched++; $display("[TB] FAIL mid_no_ack: got %b want %b", ctl, 5'b00000); end
    reset_n = 1'b1;
    tick();
    a_char = 7'o062; a_req = 1'b1;
    tick();
    compared++; if ({strobe, char_out} !== {1'b1, 7'o062}) begin mismatched++; $display("[TB] FAIL mid_next: got %b/%o want 1/%o", strobe, char_out, 7'o062); end
    tick(); key = 1'b1; tick(); key = 1'b0; a_req = 1'b0;
    compared++; if (ctl !== 5'b01000) begin mismatched++; $display("[TB] FAIL mid_next_ack: got %b want %b", ctl, 5'b01000); end
    tick(); tick();
  endtask

  task automatic test_random(input int iters);
    bit pend_a, pend_b, model_case, last_b, win_b, need_shift, pre, to_out;
    logic [6:0] ch_a, ch_b, ch;
    logic [6:0] codes[$];
    logic [4:0] want;
    int waited;
    do_reset();
    pend_a = 0; pend_b = 0; model_case = 0; last_b = 1; ch_a = '0; ch_b = '0;
    for (int it = 0; it < iters; it++) begin
      if (!pend_a && ($urandom_range(0, 1) == 1 || !pend_b)) begin ch_a = rand_char(); pend_a = 1; end
      if (!pend_b && $urandom_range(0, 1) == 1) begin ch_b = rand_char(); pend_b = 1; end
      a_req = pend_a; a_char = ch_a; b_req = pend_b; b_char = ch_b;
      pre    = ($urandom_range(0, 3) == 0);
      to_out = ($urandom_range(0, 7) == 0);
      if (pre) key = 1'b1;
      win_b  = pend_b && (!pend_a || !last_b);
      last_b = win_b;
      ch     = win_b ? ch_b : ch_a;
      if (win_b) pend_b = 0; else pend_a = 0;
      need_shift = AUTO && (ch[5:0] != 6'o72) && (ch[5:0] != 6'o74) && (ch[6] != model_case);
      codes.delete();
      if (need_shift) codes.push_back({ch[6], (ch[6] ? 6'o74 : 6'o72)});
      codes.push_back(ch);
      tick();
      if ($urandom_range(0, 1) == 1) begin if (win_b) b_char = rand_char(); else a_char = rand_char(); end
      if ($urandom_range(0, 3) == 0) begin if (win_b) b_req = 1'b0; else a_req = 1'b0; end
      for (int k = 0; k < codes.size(); k++) begin
        if (k > 0) begin
          want = {4'b0000, model_case};
          compared++; if (ctl !== want) begin mismatched++; $display("[TB] FAIL rnd%0d_shift_gap: got %b want %b", it, ctl, want); end
          tick();
        end
        compared++; if ({strobe, char_out} !== {1'b1, codes[k]}) begin mismatched++; $display("[TB] FAIL rnd%0d_code%0d: got %b/%o want 1/%o", it, k, strobe, char_out, codes[k]); end
        waited = 0;
        if (pre) begin
          tick();
          compared++; if (strobe !== 1'b1) begin mismatched++; $display("[TB] FAIL rnd%0d_stale_high: got %b want 1", it, strobe); end
          key = 1'b0;
          tick();
          waited = 2; pre = 0;
        end
        if (to_out) begin
          while (waited < T - 1) begin tick(); waited++; end
          want = {4'b1000, model_case};
          compared++; if (ctl !== want) begin mismatched++; $display("[TB] FAIL rnd%0d_to_wait: got %b want %b", it, ctl, want); end
          tick();
          want = {1'b0, !win_b, win_b, 1'b1, model_case};
          compared++; if (ctl !== want) begin mismatched++; $display("[TB] FAIL rnd%0d_to_drop: got %b want %b", it, ctl, want); end
          break;
        end
        repeat ($urandom_range(0, 3)) tick();
        key = 1'b1;
        tick();
        key = 1'b0;
        if (k == codes.size() - 1) begin
          if (ch[5:0] == 6'o72) model_case = 0;
          else if (ch[5:0] == 6'o74) model_case = 1;
          want = {1'b0, !win_b, win_b, 1'b0, model_case};
          compared++; if (ctl !== want) begin mismatched++; $display("[TB] FAIL rnd%0d_ack: got %b want %b", it, ctl, want); end
        end else begin
          model_case = ch[6];
        end
      end
      if (win_b) b_req = 1'b0; else a_req = 1'b0;
      tick();
      want = {4'b0000, model_case};
      compared++; if (ctl !== want) begin mismatched++; $display("[TB] FAIL rnd%0d_gap: got %b want %b", it, ctl, want); end
    end
  endtask

  initial begin
    test_reset();
    test_lower_char();
    test_upper_char();
    test_round_robin();
    test_timeout();
    test_reset_midtransfer();
    test_random(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
